modbus_rtu_rx_framer: RTL and testbench

MODBUS_RTU_RX_FRAMER -- requirements
Module: modbus_rtu_rx_framer

---
 rtl/modbus_pkg.sv | 28 ++
 rtl/crc16_modbus.sv | 26 ++
 rtl/modbus_rtu_rx_framer.sv | 196 +++++++++++++++++++
 tb/tb_modbus_rtu_rx_framer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/modbus_pkg.sv
// Shared definitions for the Modbus RTU receive framer: FSM encoding,
// frame limits and the bytewise CRC-16/MODBUS step.
package modbus_pkg;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_RECV,
    ST_GAP,
    ST_DONE,
    ST_DISCARD
  } state_t;

  localparam int          MIN_FRAME_LEN = 4;
  localparam logic [15:0] CRC_POLY      = 16'hA001;
  localparam logic [15:0] CRC_INIT      = 16'hFFFF;

  // Reflected CRC-16, LSB first, one whole byte per call.
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc16_modbus.sv
// Running CRC-16/MODBUS accumulator; clr restarts from 0xFFFF on the byte
// that is being stepped in the same cycle.
module crc16_modbus
  import modbus_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [15:0] crc
);

  logic [15:0] r_crc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_crc <= CRC_INIT;
    end else if (en) begin
      r_crc <= crc16_step(clr ? CRC_INIT : r_crc, data);
    end
  end

  assign crc = r_crc;

endmodule

// File: rtl/modbus_rtu_rx_framer.sv
// Modbus RTU receive framer: delimits frames by line silence, buffers the
// bytes, checks CRC residue and slave address, and holds the frame for a consumer.
module modbus_rtu_rx_framer
  import modbus_pkg::*;
#(
  parameter int T15_CYC = 1719,
  parameter int T35_CYC = 4011,
  parameter int MAX_LEN = 256
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rx_data,
  input  logic                       rx_valid,
  input  logic                       rx_err,
  input  logic [7:0]                 my_addr,
  output logic                       frm_ready,
  output logic [8:0]                 frm_len,
  output logic                       frm_crc_ok,
  output logic                       frm_addr_ok,
  input  logic                       frm_ack,
  output logic                       frm_drop,
  output logic                       frm_ovr,
  input  logic [$clog2(MAX_LEN)-1:0] rd_addr,
  output logic [7:0]                 rd_data
);

  // state   | meaning
  // INIT    | after reset, wait for 3.5-char silence before trusting the line
  // IDLE    | line quiet, next byte starts a frame
  // RECV    | collecting bytes; 1.5-char silence ends the frame body
  // GAP     | body ended; any byte is a framing violation; 3.5-char silence evaluates
  // DONE    | frame held for consumer, frm_ready high
  // DISCARD | frame abandoned, ignore bytes until 3.5-char silence

  localparam int AW = $clog2(MAX_LEN);
  localparam int CW = $clog2(T35_CYC + 1);
  localparam int LW = $clog2(MAX_LEN + 1);

  localparam logic [CW-1:0] T15_C = CW'(T15_CYC);
  localparam logic [CW-1:0] T35_C = CW'(T35_CYC);
  localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);
  localparam logic [LW-1:0] MIN_L = LW'(MIN_FRAME_LEN);

  state_t      r_state;
  logic [CW-1:0] r_cnt;
  logic [LW-1:0] r_len;
  logic [7:0]  r_byte0;
  logic        r_ready;
  logic [8:0]  r_frm_len;
  logic        r_crc_ok;
  logic        r_addr_ok;
  logic        r_drop;
  logic        r_ovr;
  logic [7:0]  r_mem [MAX_LEN];
  logic [7:0]  r_rd_data;

  logic          w_t15;
  logic          w_t35;
  logic          w_start;
  logic          w_append;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [15:0]   w_crc;

  assign w_t15 = (r_cnt == T15_C);
  assign w_t35 = (r_cnt == T35_C);

  // Only these two paths may touch the buffer, so a held frame is never overwritten.
  always_comb begin
    w_start  = 1'b0;
    w_append = 1'b0;
    case (r_state)
      ST_IDLE: w_start  = rx_valid;
      ST_RECV: w_append = rx_valid && !rx_err && (r_len != MAX_L);
      ST_DONE: w_start  = rx_valid && frm_ack && !r_ovr;
      default: ;
    endcase
  end

  assign w_we    = w_start | w_append;
  assign w_waddr = w_append ? r_len[AW-1:0] : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (rx_valid || rx_err) begin
      r_cnt <= '0;
    end else if (r_cnt != T35_C) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  crc16_modbus u_crc (
    .clk  (clk),
    .rst  (rst),
    .clr  (w_start),
    .en   (w_we),
    .data (rx_data),
    .crc  (w_crc)
  );

  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= rx_data;
    end
    r_rd_data <= r_mem[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (w_start) begin
      r_byte0 <= rx_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_INIT;
      r_len     <= '0;
      r_ready   <= 1'b0;
      r_frm_len <= '0;
      r_crc_ok  <= 1'b0;
      r_addr_ok <= 1'b0;
      r_drop    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_drop <= 1'b0;
      case (r_state)
        ST_INIT: begin
          if (w_t35) r_state <= ST_IDLE;
        end
        ST_IDLE: begin
          if (rx_valid) begin
            r_len   <= LW'(1);
            r_state <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (rx_err || (rx_valid && (r_len == MAX_L))) begin
            r_drop  <= 1'b1;
            r_state <= ST_DISCARD;
          end else if (rx_valid) begin
            r_len <= r_len + LW'(1);
          end else if (w_t15) begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (rx_err || rx_valid) begin
            r_drop  <= 1'b1;
            r_state <= ST_DISCARD;
          end else if (w_t35) begin
            if (r_len < MIN_L) begin
              r_drop  <= 1'b1;
              r_state <= ST_IDLE;
            end else begin
              r_frm_len <= 9'(r_len);
              r_crc_ok  <= (w_crc == 16'h0000);
              r_addr_ok <= (r_byte0 == my_addr) || (r_byte0 == 8'h00);
              r_ready   <= 1'b1;
              r_state   <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (frm_ack) begin
            r_ovr   <= 1'b0;
            r_ready <= 1'b0;
            if (r_ovr) begin
              r_state <= ST_DISCARD;
            end else if (rx_valid) begin
              r_len   <= LW'(1);
              r_state <= ST_RECV;
            end else begin
              r_state <= ST_IDLE;
            end
          end else if (rx_valid) begin
            r_ovr <= 1'b1;
          end
        end
        ST_DISCARD: begin
          if (w_t35) r_state <= ST_IDLE;
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign frm_ready   = r_ready;
  assign frm_len     = r_frm_len;
  assign frm_crc_ok  = r_crc_ok;
  assign frm_addr_ok = r_addr_ok;
  assign frm_drop    = r_drop;
  assign frm_ovr     = r_ovr;
  assign rd_data     = r_rd_data;

endmodule

// File: tb/tb_modbus_rtu_rx_framer.sv
// Self-checking bench for modbus_rtu_rx_framer: directed scenarios plus
// randomized frames compared against a queue-based frame model.
module tb_modbus_rtu_rx_framer;

  localparam int T15 = 20;
  localparam int T35 = 45;
  localparam int ML  = 256;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;
  logic [7:0] my_addr;
  logic       frm_ready;
  logic [8:0] frm_len;
  logic       frm_crc_ok;
  logic       frm_addr_ok;
  logic       frm_ack;
  logic       frm_drop;
  logic       frm_ovr;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;

  always #5 clk = ~clk;

  modbus_rtu_rx_framer #(.T15_CYC(T15), .T35_CYC(T35), .MAX_LEN(ML)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .my_addr(my_addr), .frm_ready(frm_ready), .frm_len(frm_len), .frm_crc_ok(frm_crc_ok),
    .frm_addr_ok(frm_addr_ok), .frm_ack(frm_ack), .frm_drop(frm_drop), .frm_ovr(frm_ovr),
    .rd_addr(rd_addr), .rd_data(rd_data)
  );

  int checks = 0;
  int errors = 0;
  int drop_cnt = 0;
  logic [7:0] fr[$];
  logic [7:0] rb[$];

  always @(negedge clk) if (frm_drop === 1'b1) drop_cnt++;

  function automatic logic [15:0] ref_crc(input logic [7:0] q[$]);
    logic [15:0] c;
    c = 16'hFFFF;
    foreach (q[i]) begin
      c = c ^ {8'h00, q[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1; tick(1); rx_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int sp);
    for (int i = first; i <= last; i++) begin
      send_byte(fr[i]);
      if (i != last) tick(sp - 1);
    end
  endtask

  task automatic wait_ready(output int lat);
    lat = 0;
    while (frm_ready !== 1'b1 && lat < T35 + 20) begin tick(1); lat++; end
  endtask

  task automatic watch_no_ready(input int n, output int seen);
    seen = 0;
    for (int i = 0; i < n; i++) begin tick(1); if (frm_ready === 1'b1) seen++; end
  endtask

  task automatic read_buf(input int n);
    rb.delete();
    for (int i = 0; i < n; i++) begin rd_addr = 8'(i); tick(1); rb.push_back(rd_data); end
  endtask

  task automatic ack();
    frm_ack = 1'b1; tick(1); frm_ack = 1'b0;
  endtask

  task automatic load_known();
    fr = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h0A, 8'hC5, 8'hCD};
  endtask

  task automatic make_frame(input int len, input bit good);
    logic [15:0] c;
    fr.delete();
    for (int i = 0; i < len - 2; i++) fr.push_back(8'($urandom));
    if ($urandom_range(0, 3) == 0) fr[0] = 8'h00;
    c = ref_crc(fr);
    fr.push_back(c[7:0]);
    fr.push_back(c[15:8]);
    if (!good) fr[len-1] = fr[len-1] ^ 8'($urandom_range(1, 255));
  endtask

  task automatic test_reset();
    int lat;
    rst = 1'b1; tick(3);
    checks++; if (frm_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", frm_ready); end
    checks++; if (frm_len !== 9'd0) begin errors++; $display("FAIL reset_len got %0d want 0", frm_len); end
    checks++; if ({frm_crc_ok, frm_addr_ok, frm_drop, frm_ovr} !== 4'b0000)
      begin errors++; $display("FAIL reset_flags got %b want 0000", {frm_crc_ok, frm_addr_ok, frm_drop, frm_ovr}); end
    rst = 1'b0; tick(5);
    send_byte(8'h55);
    tick(T35 + 5);
    my_addr = 8'h01; load_known(); send_range(0, 7, 10);
    wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd8)
      begin errors++; $display("FAIL init_ignore ready %b len %0d want 1 8", frm_ready, frm_len); end
    ack();
  endtask

  task automatic test_known_frame();
    int lat, base, bad;
    my_addr = 8'h01; load_known(); base = drop_cnt;
    send_range(0, 7, 10);
    wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || lat < T35 || lat > T35 + 2)
      begin errors++; $display("FAIL known_latency ready %b lat %0d want %0d..%0d", frm_ready, lat, T35, T35 + 2); end
    checks++; if (frm_len !== 9'd8) begin errors++; $display("FAIL known_len got %0d want 8", frm_len); end
    checks++; if (frm_crc_ok !== 1'b1) begin errors++; $display("FAIL known_crc got %b want 1", frm_crc_ok); end
    checks++; if (frm_addr_ok !== 1'b1) begin errors++; $display("FAIL known_addr got %b want 1", frm_addr_ok); end
    read_buf(8);
    for (int i = 0; i < 8; i++) begin
      checks++; if (rb[i] !== fr[i]) begin errors++; $display("FAIL known_rd[%0d] got %h want %h", i, rb[i], fr[i]); end
    end
    bad = drop_cnt - base;
    checks++; if (bad != 0) begin errors++; $display("FAIL known_nodrop got %0d want 0", bad); end
    ack(); tick(1);
    checks++; if (frm_ready !== 1'b0) begin errors++; $display("FAIL known_ack_ready got %b want 0", frm_ready); end
  endtask

  task automatic test_bad_crc_and_broadcast();
    int lat;
    logic [15:0] c;
    my_addr = 8'h01; load_known(); fr[7] = 8'hCC;
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_crc_ok !== (ref_crc(fr) == 16'h0))
      begin errors++; $display("FAIL badcrc ready %b crc_ok %b want 1 %b", frm_ready, frm_crc_ok, ref_crc(fr) == 16'h0); end
    ack();
    load_known(); fr[0] = 8'h00; fr = fr[0:5]; c = ref_crc(fr);
    fr.push_back(c[7:0]); fr.push_back(c[15:8]); my_addr = 8'h05;
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_addr_ok !== 1'b1 || frm_crc_ok !== 1'b1)
      begin errors++; $display("FAIL broadcast ready %b addr %b crc %b want 1 1 1", frm_ready, frm_addr_ok, frm_crc_ok); end
    ack();
  endtask

  task automatic test_gap();
    int lat, base, seen;
    my_addr = 8'h01; load_known(); base = drop_cnt;
    send_range(0, 2, 10); tick(T15 + 4); send_range(3, 7, 10);
    watch_no_ready(T35 + 10, seen);
    checks++; if (drop_cnt != base + 1 || seen != 0)
      begin errors++; $display("FAIL gap_drop drops %0d ready_seen %0d want 1 0", drop_cnt - base, seen); end
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd8 || frm_crc_ok !== 1'b1)
      begin errors++; $display("FAIL gap_recover ready %b len %0d crc %b want 1 8 1", frm_ready, frm_len, frm_crc_ok); end
    ack();
  endtask

  task automatic test_overflow();
    int lat, base, seen;
    fr.delete();
    for (int i = 0; i < ML + 1; i++) fr.push_back(8'($urandom));
    base = drop_cnt;
    send_range(0, ML - 1, 2); tick(1);
    checks++; if (drop_cnt != base || frm_ready !== 1'b0)
      begin errors++; $display("FAIL ovf_full drops %0d ready %b want 0 0", drop_cnt - base, frm_ready); end
    send_byte(fr[ML]); tick(1);
    checks++; if (drop_cnt != base + 1) begin errors++; $display("FAIL ovf_drop drops %0d want 1", drop_cnt - base); end
    tick(T35 - 10);
    make_frame(6, 1'b1); my_addr = fr[0];
    send_range(0, 5, 3);
    watch_no_ready(T35 + 10, seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL ovf_discard ready_seen %0d want 0", seen); end
    my_addr = 8'h01; load_known(); send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd8)
      begin errors++; $display("FAIL ovf_recover ready %b len %0d want 1 8", frm_ready, frm_len); end
    ack();
  endtask

  task automatic test_short();
    int base, seen;
    fr = '{8'h01, 8'h02}; base = drop_cnt;
    send_range(0, 1, 5);
    watch_no_ready(T35 + 10, seen);
    checks++; if (drop_cnt != base + 1 || seen != 0)
      begin errors++; $display("FAIL short drops %0d ready_seen %0d want 1 0", drop_cnt - base, seen); end
  endtask

  task automatic test_overrun();
    int lat, seen, bad;
    my_addr = 8'h01; load_known(); send_range(0, 7, 10); wait_ready(lat);
    for (int i = 0; i < 3; i++) begin send_byte(8'($urandom)); tick(4); end
    checks++; if (frm_ovr !== 1'b1 || frm_ready !== 1'b1 || frm_len !== 9'd8)
      begin errors++; $display("FAIL ovr_set ovr %b ready %b len %0d want 1 1 8", frm_ovr, frm_ready, frm_len); end
    read_buf(8); bad = 0;
    for (int i = 0; i < 8; i++) if (rb[i] !== fr[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ovr_buf bytes_changed %0d want 0", bad); end
    ack();
    checks++; if (frm_ovr !== 1'b0 || frm_ready !== 1'b0)
      begin errors++; $display("FAIL ovr_ack ovr %b ready %b want 0 0", frm_ovr, frm_ready); end
    send_range(0, 7, 10);
    watch_no_ready(T35 + 10, seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL ovr_discard ready_seen %0d want 0", seen); end
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_crc_ok !== 1'b1)
      begin errors++; $display("FAIL ovr_recover ready %b crc %b want 1 1", frm_ready, frm_crc_ok); end
    ack();
  endtask

  task automatic test_back_to_back();
    int lat, bad;
    my_addr = 8'h01; load_known(); send_range(0, 7, 10); wait_ready(lat);
    make_frame(6, 1'b1); my_addr = fr[0];
    rx_data = fr[0]; rx_valid = 1'b1; frm_ack = 1'b1; tick(1);
    rx_valid = 1'b0; frm_ack = 1'b0;
    tick(9); send_range(1, 5, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd6 || frm_crc_ok !== 1'b1 || frm_addr_ok !== 1'b1)
      begin errors++; $display("FAIL restart ready %b len %0d crc %b addr %b want 1 6 1 1", frm_ready, frm_len, frm_crc_ok, frm_addr_ok); end
    read_buf(6); bad = 0;
    for (int i = 0; i < 6; i++) if (rb[i] !== fr[i]) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL restart_buf bad_bytes %0d want 0", bad); end
    ack();
  endtask

  task automatic test_rx_err();
    int lat, base, seen;
    my_addr = 8'h01; load_known(); base = drop_cnt;
    send_range(0, 3, 10); tick(4);
    rx_err = 1'b1; tick(1); rx_err = 1'b0; tick(1);
    checks++; if (drop_cnt != base + 1) begin errors++; $display("FAIL rxerr_drop drops %0d want 1", drop_cnt - base); end
    send_range(4, 7, 10);
    watch_no_ready(T35 + 10, seen);
    checks++; if (seen != 0) begin errors++; $display("FAIL rxerr_noready ready_seen %0d want 0", seen); end
    rx_err = 1'b1; tick(1); rx_err = 1'b0; tick(3);
    checks++; if (drop_cnt != base + 1) begin errors++; $display("FAIL rxerr_idle drops %0d want 1", drop_cnt - base); end
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd8)
      begin errors++; $display("FAIL rxerr_recover ready %b len %0d want 1 8", frm_ready, frm_len); end
    ack();
  endtask

  task automatic test_rst_mid();
    int lat, base;
    my_addr = 8'h01; load_known(); base = drop_cnt;
    send_range(0, 3, 10);
    rst = 1'b1; tick(2);
    checks++; if ({frm_ready, frm_crc_ok, frm_addr_ok, frm_drop, frm_ovr} !== 5'b0 || frm_len !== 9'd0 || drop_cnt != base)
      begin errors++; $display("FAIL rst_mid flags %b len %0d drops %0d want 0 0 0",
        {frm_ready, frm_crc_ok, frm_addr_ok, frm_drop, frm_ovr}, frm_len, drop_cnt - base); end
    rst = 1'b0; tick(T35 + 5);
    send_range(0, 7, 10); wait_ready(lat);
    checks++; if (frm_ready !== 1'b1 || frm_len !== 9'd8 || frm_crc_ok !== 1'b1)
      begin errors++; $display("FAIL rst_recover ready %b len %0d crc %b want 1 8 1", frm_ready, frm_len, frm_crc_ok); end
    rst = 1'b1; tick(1);
    checks++; if ({frm_ready, frm_crc_ok, frm_addr_ok} !== 3'b0 || frm_len !== 9'd0)
      begin errors++; $display("FAIL rst_done flags %b len %0d want 000 0", {frm_ready, frm_crc_ok, frm_addr_ok}, frm_len); end
    rst = 1'b0; tick(T35 + 5);
  endtask

  task automatic test_random_frames();
    int lat, len, sp, bad;
    bit good, exp_crc, exp_addr;
    for (int n = 0; n < 12; n++) begin
      len  = $urandom_range(4, 24);
      good = ($urandom_range(0, 3) != 0);
      make_frame(len, good);
      my_addr = ($urandom_range(0, 1) == 1) ? fr[0] : 8'($urandom);
      exp_crc  = (ref_crc(fr) == 16'h0000);
      exp_addr = (fr[0] == my_addr) || (fr[0] == 8'h00);
      sp = $urandom_range(1, T15 - 3);
      send_range(0, len - 1, sp); wait_ready(lat);
      checks++; if (frm_ready !== 1'b1 || frm_len !== 9'(len))
        begin errors++; $display("FAIL rand%0d_len ready %b len %0d want 1 %0d", n, frm_ready, frm_len, len); end
      checks++; if (frm_crc_ok !== exp_crc || frm_addr_ok !== exp_addr)
        begin errors++; $display("FAIL rand%0d_flags crc %b addr %b want %b %b", n, frm_crc_ok, frm_addr_ok, exp_crc, exp_addr); end
      read_buf(len); bad = 0;
      for (int i = 0; i < len; i++) if (rb[i] !== fr[i]) bad++;
      checks++; if (bad != 0) begin errors++; $display("FAIL rand%0d_buf bad_bytes %0d want 0", n, bad); end
      ack();
    end
  endtask

  initial begin
    rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
    my_addr = 8'h01; frm_ack = 1'b0; rd_addr = 8'h00;
    test_reset();
    test_known_frame();
    test_bad_crc_and_broadcast();
    test_gap();
    test_overflow();
    test_short();
    test_overrun();
    test_back_to_back();
    test_rx_err();
    test_rst_mid();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
